cpu_regfile_arbiter: RTL and testbench

Arbitrates access to the CPU general-purpose register file between two requesters: port 0, the control unit, and port 1, the debug/loader port. It serialises their read, write and register-move requests onto the register file's single select/write-enable/output-enable interface. Request/acknowledge handshakes run on each port. A move is sequenced as a read into an internal holding register followed by a write.

---
 rtl/cpu_regfile_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_cpu_regfile_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_regfile_arbiter.sv
// cpu_regfile_arbiter: serialises read/write/move requests from two ports (0 = control
//   unit, 1 = debug/loader) onto one register-file select/we/oe interface.
// Ports: clk, rst_n (async, active low); per port reqN/opN/srcN/dstN/wdataN in,
//   ackN/errN/rdataN out; rf_sel/rf_we/rf_oe/rf_wdata out, rf_rdata in; busy out.
// Latency: read/write ack 2 cycles after the IDLE sample, move 3, error 1.
// Build option: define REGARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties);
//   otherwise ties are broken round-robin.

module cpu_regfile_arbiter #(
  parameter int NUM_REGS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [1:0] op0,
  input  logic [2:0] src0,
  input  logic [2:0] dst0,
  input  logic [7:0] wdata0,
  output logic       ack0,
  output logic       err0,
  output logic [7:0] rdata0,
  input  logic       req1,
  input  logic [1:0] op1,
  input  logic [2:0] src1,
  input  logic [2:0] dst1,
  input  logic [7:0] wdata1,
  output logic       ack1,
  output logic       err1,
  output logic [7:0] rdata1,
  output logic [2:0] rf_sel,
  output logic       rf_we,
  output logic       rf_oe,
  output logic [7:0] rf_wdata,
  input  logic [7:0] rf_rdata,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, RD, WR, MV_RD, MV_WR, ACK} state_t;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_MV = 2'b10;
  localparam logic [3:0] NREGS = 4'(NUM_REGS);

  state_t     state, state_nxt;
  logic       win;        // port being served
  logic [1:0] op_q;
  logic [2:0] src_q, dst_q;
  logic [7:0] wdata_q;
  logic       err_q;
  logic [7:0] hold;       // holds read data; also the source value of a move
  logic [7:0] rdata0_q, rdata1_q;
`ifndef REGARB_FIXED_PRIO_EN
  logic       last;       // port granted most recently
`endif

  logic       any_req, gnt;
  logic [1:0] req_op;
  logic [2:0] req_src, req_dst;
  logic [7:0] req_wdata;
  logic       req_bad;
  logic       load_rdata;

  assign any_req = req0 | req1;

`ifdef REGARB_FIXED_PRIO_EN
  assign gnt = ~req0;
`else
  // A lone requester wins outright; on a tie the port not granted last time wins.
  assign gnt = (req0 & req1) ? ~last : req1;
`endif

  assign req_op    = gnt ? op1    : op0;
  assign req_src   = gnt ? src1   : src0;
  assign req_dst   = gnt ? dst1   : dst0;
  assign req_wdata = gnt ? wdata1 : wdata0;

  // Only addresses the op actually uses are range-checked.
  always_comb begin
    req_bad = 1'b0;
    case (req_op)
      OP_RD, OP_WR: req_bad = ({1'b0, req_src} >= NREGS);
      OP_MV:        req_bad = ({1'b0, req_src} >= NREGS) || ({1'b0, req_dst} >= NREGS);
      default:      req_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (req_bad)              state_nxt = ACK;
          else if (req_op == OP_RD) state_nxt = RD;
          else if (req_op == OP_WR) state_nxt = WR;
          else                      state_nxt = MV_RD;
        end
      end
      RD:      state_nxt = ACK;
      WR:      state_nxt = ACK;
      MV_RD:   state_nxt = MV_WR;
      MV_WR:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign load_rdata = ~err_q && ((op_q == OP_RD) || (op_q == OP_MV));

  // Outputs decode from registered state only, so an async reset clears them at once.
  always_comb begin
    rf_sel   = 3'd0;
    rf_we    = 1'b0;
    rf_oe    = 1'b0;
    rf_wdata = 8'h00;
    ack0     = 1'b0;
    ack1     = 1'b0;
    case (state)
      RD, MV_RD: begin
        rf_sel = src_q;
        rf_oe  = 1'b1;
      end
      WR: begin
        rf_sel   = src_q;
        rf_we    = 1'b1;
        rf_wdata = wdata_q;
      end
      MV_WR: begin
        rf_sel   = dst_q;
        rf_we    = 1'b1;
        rf_wdata = hold;
      end
      ACK: begin
        ack0 = ~win;
        ack1 = win;
      end
      default: ;
    endcase
  end

  assign err0   = ack0 & err_q;
  assign err1   = ack1 & err_q;
  // Fresh data is presented during the ack cycle itself, then held in rdataN_q.
  assign rdata0 = (ack0 && load_rdata) ? hold : rdata0_q;
  assign rdata1 = (ack1 && load_rdata) ? hold : rdata1_q;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      win      <= 1'b0;
      op_q     <= 2'b00;
      src_q    <= 3'd0;
      dst_q    <= 3'd0;
      wdata_q  <= 8'h00;
      err_q    <= 1'b0;
      hold     <= 8'h00;
      rdata0_q <= 8'h00;
      rdata1_q <= 8'h00;
`ifndef REGARB_FIXED_PRIO_EN
      last     <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        win     <= gnt;
        op_q    <= req_op;
        src_q   <= req_src;
        dst_q   <= req_dst;
        wdata_q <= req_wdata;
        err_q   <= req_bad;
`ifndef REGARB_FIXED_PRIO_EN
        last    <= gnt;
`endif
      end
      if (state == RD || state == MV_RD) hold <= rf_rdata;
      if (state == ACK && load_rdata) begin
        if (win) rdata1_q <= hold;
        else     rdata0_q <= hold;
      end
    end
  end

endmodule

// File: tb/tb_cpu_regfile_arbiter.sv
// tb_cpu_regfile_arbiter: directed stimulus against cpu_regfile_arbiter with a
// behavioural 8-entry register file attached to the rf_* interface.

module tb_cpu_regfile_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [1:0] op0, op1;
  logic [2:0] src0, src1, dst0, dst1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, err0, err1;
  logic [7:0] rdata0, rdata1;
  logic [2:0] rf_sel;
  logic       rf_we, rf_oe;
  logic [7:0] rf_wdata, rf_rdata;
  logic       busy;

  int n_chk;
  int n_fail;

  logic [7:0] rf_mem [0:7] = '{default: 8'h00};

  always @(posedge clk) if (rf_we) rf_mem[rf_sel] <= rf_wdata;
  assign rf_rdata = rf_oe ? rf_mem[rf_sel] : 8'hEE;

  cpu_regfile_arbiter #(.NUM_REGS(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .src0(src0), .dst0(dst0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .op1(op1), .src1(src1), .dst1(dst1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .rf_sel(rf_sel), .rf_we(rf_we), .rf_oe(rf_oe), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge, wait for its ack, check latency/err/rdata and
  // how many cycles rf_we/rf_oe were high. Returns the last write select/data seen.
  task automatic xact(input string tag, input bit port, input logic [1:0] op,
                      input logic [2:0] src, input logic [2:0] dst, input logic [7:0] wd,
                      input int exp_lat, input logic exp_err, input logic [7:0] exp_rd,
                      input int exp_we, input int exp_oe,
                      output logic [2:0] we_sel, output logic [7:0] we_dat);
    int lat, we_n, oe_n;
    bit got, both;
    logic err_s;
    logic [7:0] rd_s;
    if (port) begin req1 = 1; op1 = op; src1 = src; dst1 = dst; wdata1 = wd; end
    else      begin req0 = 1; op0 = op; src0 = src; dst0 = dst; wdata0 = wd; end
    lat = 0; we_n = 0; oe_n = 0; got = 0; both = 0;
    err_s = 1'bx; rd_s = 8'hxx; we_sel = 3'd0; we_dat = 8'h00;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (rf_we) begin we_n++; we_sel = rf_sel; we_dat = rf_wdata; end
      if (rf_oe) oe_n++;
      if (rf_we && rf_oe) both = 1;
      if (port ? ack1 : ack0) begin
        got   = 1;
        err_s = port ? err1 : err0;
        rd_s  = port ? rdata1 : rdata0;
      end
    end
    if (port) req1 = 0; else req0 = 0;
    chk({tag, "/latency"}, lat, exp_lat);
    chk({tag, "/err"}, err_s, exp_err);
    chk({tag, "/rdata"}, rd_s, exp_rd);
    chk({tag, "/we_cycles"}, we_n, exp_we);
    chk({tag, "/oe_cycles"}, oe_n, exp_oe);
    chk({tag, "/we_oe_overlap"}, both, 0);
    @(negedge clk);
    chk({tag, "/idle_after"}, {busy, ack0, ack1}, 3'b000);
  endtask

  // Both ports read continuously, n reads each; port 0 reads reg 0, port 1 reads reg 2.
  task automatic run_tie(input string tag, input int n, input logic [7:0] exp0, input logic [7:0] exp1);
    int order [0:15];
    int k, c0, c1, cyc, want;
    req0 = 1; op0 = 2'b00; src0 = 3'd0; dst0 = 3'd0;
    req1 = 1; op1 = 2'b00; src1 = 3'd2; dst1 = 3'd0;
    k = 0; c0 = 0; c1 = 0; cyc = 0;
    while (k < 2 * n && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ack0) begin
        order[k] = 0; k++; c0++;
        chk({tag, "/rdata0"}, rdata0, exp0);
        if (c0 == n) req0 = 0;
      end
      if (ack1) begin
        order[k] = 1; k++; c1++;
        chk({tag, "/rdata1"}, rdata1, exp1);
        if (c1 == n) req1 = 0;
      end
    end
    req0 = 0; req1 = 0;
    chk({tag, "/acks"}, k, 2 * n);
    for (int i = 0; i < k; i++) begin
`ifdef REGARB_FIXED_PRIO_EN
      want = (i < n) ? 0 : 1;
`else
      want = i % 2;
`endif
      chk($sformatf("%s/grant%0d", tag, i), order[i], want);
    end
    @(negedge clk);
  endtask

  logic [2:0] ws;
  logic [7:0] wdv;

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 0;
    req0 = 0; op0 = 0; src0 = 0; dst0 = 0; wdata0 = 0;
    req1 = 0; op1 = 0; src1 = 0; dst1 = 0; wdata1 = 0;
    repeat (2) @(negedge clk);
    chk("reset/ctl", {busy, ack0, ack1, err0, err1, rf_we, rf_oe}, 7'b0);
    chk("reset/rf_sel", rf_sel, 3'd0);
    chk("reset/rf_wdata", rf_wdata, 8'h00);
    chk("reset/rdata", {rdata0, rdata1}, 16'h0000);
    rst_n = 1;
    @(negedge clk);
    chk("reset/busy_after", busy, 1'b0);

    // write, read back, move, read moved value
    xact("wr_p0_r1", 0, 2'b01, 3'd1, 3'd0, 8'h5A, 2, 1'b0, 8'h00, 1, 0, ws, wdv);
    chk("wr_p0_r1/sel", ws, 3'd1);
    chk("wr_p0_r1/wdata", wdv, 8'h5A);
    chk("wr_p0_r1/mem", rf_mem[1], 8'h5A);
    xact("rd_p1_r1", 1, 2'b00, 3'd1, 3'd0, 8'h00, 2, 1'b0, 8'h5A, 0, 1, ws, wdv);
    xact("mv_p0_1to2", 0, 2'b10, 3'd1, 3'd2, 8'h00, 3, 1'b0, 8'h5A, 1, 1, ws, wdv);
    chk("mv_p0_1to2/sel", ws, 3'd2);
    chk("mv_p0_1to2/wdata", wdv, 8'h5A);
    xact("rd_p1_r2", 1, 2'b00, 3'd2, 3'd0, 8'h00, 2, 1'b0, 8'h5A, 0, 1, ws, wdv);
    xact("wr_p1_r0", 1, 2'b01, 3'd0, 3'd0, 8'h33, 2, 1'b0, 8'h5A, 1, 0, ws, wdv);
    chk("wr_p1_r0/wdata", wdv, 8'h33);

    // invalid requests: rdata stays at its previous value
    xact("err_rd_src3", 0, 2'b00, 3'd3, 3'd0, 8'h00, 1, 1'b1, 8'h5A, 0, 0, ws, wdv);
    xact("err_op11", 1, 2'b11, 3'd0, 3'd0, 8'h00, 1, 1'b1, 8'h5A, 0, 0, ws, wdv);
    xact("err_mv_dst7", 0, 2'b10, 3'd0, 3'd7, 8'h00, 1, 1'b1, 8'h5A, 0, 0, ws, wdv);
    xact("err_wr_dst3", 0, 2'b01, 3'd3, 3'd0, 8'hFF, 1, 1'b1, 8'h5A, 0, 0, ws, wdv);
    chk("err_wr_dst3/mem3", rf_mem[3], 8'h00);
    // a read ignores dst, so an out-of-range dst is not an error
    xact("rd_p0_r0_dst7", 0, 2'b00, 3'd0, 3'd7, 8'h00, 2, 1'b0, 8'h33, 0, 1, ws, wdv);
    xact("rd_p1_r2b", 1, 2'b00, 3'd2, 3'd0, 8'h00, 2, 1'b0, 8'h5A, 0, 1, ws, wdv);

    // simultaneous requesters, 3 reads each
    run_tie("tie3", 3, 8'h33, 8'h5A);

    // reset during the write half of a move 0->2
    xact("wr_p0_r2", 0, 2'b01, 3'd2, 3'd0, 8'h11, 2, 1'b0, 8'h33, 1, 0, ws, wdv);
    req0 = 1; op0 = 2'b10; src0 = 3'd0; dst0 = 3'd2;
    @(negedge clk);
    chk("mvrst/mv_rd_oe", {rf_oe, rf_we, rf_sel}, {1'b1, 1'b0, 3'd0});
    @(negedge clk);
    chk("mvrst/mv_wr_we", {rf_oe, rf_we, rf_sel}, {1'b0, 1'b1, 3'd2});
    rst_n = 0;
    #1;
    chk("mvrst/ctl", {busy, ack0, ack1, err0, err1, rf_we, rf_oe}, 7'b0);
    chk("mvrst/rf_sel", rf_sel, 3'd0);
    chk("mvrst/rf_wdata", rf_wdata, 8'h00);
    chk("mvrst/rdata", {rdata0, rdata1}, 16'h0000);
    req0 = 0;
    @(negedge clk);
    rst_n = 1;
    chk("mvrst/mem2", rf_mem[2], 8'h11);
    // first tie after reset goes to port 0
    run_tie("tie_after_rst", 1, 8'h33, 8'h11);
    xact("rd_p1_r2_after_rst", 1, 2'b00, 3'd2, 3'd0, 8'h00, 2, 1'b0, 8'h11, 0, 1, ws, wdv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
